// File: rtl/sensor_pkg.sv
// Shared types and width helpers for the pixel sensor frame sequencer.
package sensor_pkg;

    // Frame-level sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_EXPOSE,
        ST_CONVERT,
        ST_READ,
        ST_DONE
    } state_t;

    // Sub-phases of one row slot during READ
    typedef enum logic [1:0] {
        RD_SELECT,
        RD_CAPTURE,
        RD_SHIFT
    } rd_phase_t;

    // Registered single-bit control outputs, kept together so they update as one word
    typedef struct packed {
        logic erase;
        logic expose;
        logic convert;
        logic read_clk;
        logic write_clk;
        logic busy;
        logic frame_done;
    } ctl_t;

    // Bits needed to hold the values 0..max_val
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed to index n items (at least 1)
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Widths for the default array geometry
    localparam int DEF_BIT_DEPTH = 8;
    localparam int DEF_HEIGHT    = 2;
    localparam int DEF_ROW_W     = idx_w(DEF_HEIGHT);

endpackage

// File: rtl/gray_counter.sv
// Binary up-counter with a registered Gray-coded copy for the pixel latches.
// Gray output always equals bin ^ (bin >> 1) of the binary value held alongside it.
module gray_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray
);

    logic [W-1:0] bin_nxt;

    assign bin_nxt = bin + 1'b1;

    // Count on enable, clear synchronously; clear wins over enable
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bin  <= '0;
            gray <= '0;
        end else if (clr) begin
            bin  <= '0;
            gray <= '0;
        end else if (en) begin
            bin  <= bin_nxt;
            gray <= bin_nxt ^ (bin_nxt >> 1);
        end
    end

endmodule

// File: rtl/pixel_sensor_controller.sv
// Frame sequencer: erase -> expose -> single-slope convert -> row readout -> done.
// Every output is registered from the next-state values, so it lines up with the state.
module pixel_sensor_controller
    import sensor_pkg::*;
#(
    parameter int BIT_DEPTH              = 8,
    parameter int WIDTH                  = 2,
    parameter int HEIGHT                 = 2,
    parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
    parameter int ERASE_CYCLES           = 5,
    parameter int EXPOSE_CYCLES          = 255
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    output logic                 ERASE,
    output logic                 EXPOSE,
    output logic                 CONVERT,
    output logic [BIT_DEPTH-1:0] COUNTER,
    output logic [HEIGHT-1:0]    ROW_SELECT,
    output logic                 READ_CLK,
    output logic                 WRITE_CLK,
    output logic                 BUSY,
    output logic                 FRAME_DONE
);

    // Output-bus words per row
    localparam int K      = WIDTH / OUTPUT_BUS_PIXEL_WIDTH;
    localparam int PH_MAX = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
    localparam int PH_W   = cnt_w(PH_MAX - 1);
    localparam int ROW_W  = idx_w(HEIGHT);
    localparam int WORD_W = idx_w(K);

    localparam logic [PH_W-1:0]   ERASE_LAST  = PH_W'(ERASE_CYCLES - 1);
    localparam logic [PH_W-1:0]   EXPOSE_LAST = PH_W'(EXPOSE_CYCLES - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(HEIGHT - 1);
    localparam logic [WORD_W-1:0] WORD_LAST   = WORD_W'(K - 1);

    state_t            state, nxt_state;
    rd_phase_t         rd_phase, nxt_rd;
    logic              half, nxt_half;     // 0: strobe slot, 1: following low cycle
    logic [PH_W-1:0]   ph_cnt, nxt_ph;
    logic [ROW_W-1:0]  row_idx, nxt_row;
    logic [WORD_W-1:0] word_idx, nxt_word;

    logic                 gc_en, gc_clr;
    logic [BIT_DEPTH-1:0] gc_bin, gc_gray;
    ctl_t                 ctl_q;

    // The binary side doubles as the CONVERT phase counter
    gray_counter #(
        .W (BIT_DEPTH)
    ) u_gray (
        .CLK   (CLK),
        .RESET (RESET),
        .en    (gc_en),
        .clr   (gc_clr),
        .bin   (gc_bin),
        .gray  (gc_gray)
    );

    // State and index registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= ST_IDLE;
            rd_phase <= RD_SELECT;
            half     <= 1'b0;
            ph_cnt   <= '0;
            row_idx  <= '0;
            word_idx <= '0;
        end else begin
            state    <= nxt_state;
            rd_phase <= nxt_rd;
            half     <= nxt_half;
            ph_cnt   <= nxt_ph;
            row_idx  <= nxt_row;
            word_idx <= nxt_word;
        end
    end

    // Next-state, phase counters and Gray counter control
    always_comb begin
        nxt_state = state;
        nxt_rd    = rd_phase;
        nxt_half  = half;
        nxt_ph    = ph_cnt;
        nxt_row   = row_idx;
        nxt_word  = word_idx;
        gc_en     = 1'b0;
        gc_clr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    nxt_state = ST_ERASE;
                    nxt_ph    = '0;
                end
            end
            ST_ERASE: begin
                if (ph_cnt == ERASE_LAST) begin
                    nxt_state = ST_EXPOSE;
                    nxt_ph    = '0;
                end else begin
                    nxt_ph = ph_cnt + 1'b1;
                end
            end
            ST_EXPOSE: begin
                if (ph_cnt == EXPOSE_LAST) begin
                    nxt_state = ST_CONVERT;
                    nxt_ph    = '0;
                    gc_clr    = 1'b1;   // first CONVERT cycle shows code 0
                end else begin
                    nxt_ph = ph_cnt + 1'b1;
                end
            end
            ST_CONVERT: begin
                if (&gc_bin) begin
                    // Stop counting so the final code is held through READ
                    nxt_state = ST_READ;
                    nxt_rd    = RD_SELECT;
                    nxt_half  = 1'b0;
                    nxt_row   = '0;
                    nxt_word  = '0;
                end else begin
                    gc_en = 1'b1;
                end
            end
            ST_READ: begin
                case (rd_phase)
                    RD_SELECT: begin
                        nxt_rd   = RD_CAPTURE;
                        nxt_half = 1'b0;
                    end
                    RD_CAPTURE: begin
                        if (!half) begin
                            nxt_half = 1'b1;
                        end else begin
                            nxt_rd   = RD_SHIFT;
                            nxt_half = 1'b0;
                            nxt_word = '0;
                        end
                    end
                    RD_SHIFT: begin
                        if (!half) begin
                            nxt_half = 1'b1;
                        end else if (word_idx == WORD_LAST) begin
                            nxt_half = 1'b0;
                            nxt_word = '0;
                            if (row_idx == ROW_LAST) begin
                                nxt_state = ST_DONE;
                                gc_clr    = 1'b1;   // code returns to 0 in DONE
                            end else begin
                                nxt_row = row_idx + 1'b1;
                                nxt_rd  = RD_SELECT;
                            end
                        end else begin
                            nxt_word = word_idx + 1'b1;
                            nxt_half = 1'b0;
                        end
                    end
                    default: nxt_rd = RD_SELECT;
                endcase
            end
            ST_DONE: nxt_state = ST_IDLE;
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Output registers decoded from the next state so they align with it
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ctl_q      <= '0;
            ROW_SELECT <= '0;
        end else begin
            ctl_q.erase      <= (nxt_state == ST_ERASE);
            ctl_q.expose     <= (nxt_state == ST_EXPOSE);
            ctl_q.convert    <= (nxt_state == ST_CONVERT);
            ctl_q.read_clk   <= (nxt_state == ST_READ) && (nxt_rd == RD_CAPTURE) && !nxt_half;
            ctl_q.write_clk  <= (nxt_state == ST_READ) && (nxt_rd == RD_SHIFT) && !nxt_half;
            ctl_q.busy       <= (nxt_state != ST_IDLE);
            ctl_q.frame_done <= (nxt_state == ST_DONE);
            ROW_SELECT       <= (nxt_state == ST_READ) ? (HEIGHT'(1) << nxt_row) : '0;
        end
    end

    assign ERASE      = ctl_q.erase;
    assign EXPOSE     = ctl_q.expose;
    assign CONVERT    = ctl_q.convert;
    assign READ_CLK   = ctl_q.read_clk;
    assign WRITE_CLK  = ctl_q.write_clk;
    assign BUSY       = ctl_q.busy;
    assign FRAME_DONE = ctl_q.frame_done;
    assign COUNTER    = gc_gray;

endmodule

// File: tb/tb_pixel_sensor_controller.sv
// Bench for pixel_sensor_controller: two instances (K=1 and K=4), per-cycle
// comparison against a timeline model, a checkpoint table and corner sequences.
module tb_pixel_sensor_controller;

    localparam int E_C   = 5;
    localparam int X_C   = 20;
    localparam int NCONV = 256;
    localparam int H     = 2;

    typedef struct packed {
        logic       erase;
        logic       expose;
        logic       convert;
        logic [7:0] counter;
        logic [1:0] row;
        logic       rclk;
        logic       wclk;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        int   t;
        obs_t e;
    } vec_t;

    logic CLK, RESET, start_a, start_b;
    logic a_erase, a_expose, a_convert, a_rclk, a_wclk, a_busy, a_done;
    logic b_erase, b_expose, b_convert, b_rclk, b_wclk, b_busy, b_done;
    logic [7:0] a_counter, b_counter;
    logic [1:0] a_row, b_row;

    int   n_chk = 0;
    int   n_err = 0;
    obs_t trace_a [0:299];
    vec_t tbl [$];

    pixel_sensor_controller #(
        .BIT_DEPTH(8), .WIDTH(2), .HEIGHT(2), .OUTPUT_BUS_PIXEL_WIDTH(2),
        .ERASE_CYCLES(E_C), .EXPOSE_CYCLES(X_C)
    ) dut_a (
        .CLK(CLK), .RESET(RESET), .START(start_a),
        .ERASE(a_erase), .EXPOSE(a_expose), .CONVERT(a_convert), .COUNTER(a_counter),
        .ROW_SELECT(a_row), .READ_CLK(a_rclk), .WRITE_CLK(a_wclk),
        .BUSY(a_busy), .FRAME_DONE(a_done)
    );

    pixel_sensor_controller #(
        .BIT_DEPTH(8), .WIDTH(8), .HEIGHT(2), .OUTPUT_BUS_PIXEL_WIDTH(2),
        .ERASE_CYCLES(E_C), .EXPOSE_CYCLES(X_C)
    ) dut_b (
        .CLK(CLK), .RESET(RESET), .START(start_b),
        .ERASE(b_erase), .EXPOSE(b_expose), .CONVERT(b_convert), .COUNTER(b_counter),
        .ROW_SELECT(b_row), .READ_CLK(b_rclk), .WRITE_CLK(b_wclk),
        .BUSY(b_busy), .FRAME_DONE(b_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected outputs t cycles after ERASE rose, from the phase-length arithmetic
    function automatic obs_t model(input int t, input int k);
        obs_t o;
        int c0, r0, d0, slot, b, s, r;
        o    = '0;
        slot = 3 + 2 * k;
        c0   = E_C + X_C;
        r0   = c0 + NCONV;
        d0   = r0 + H * slot;
        if (t >= 0 && t <= d0) begin
            o.busy = 1'b1;
            if (t < E_C) o.erase = 1'b1;
            else if (t < c0) o.expose = 1'b1;
            else if (t < r0) begin
                o.convert = 1'b1;
                b = t - c0;
                o.counter = 8'(b ^ (b >> 1));
            end else if (t < d0) begin
                s = (t - r0) % slot;
                r = (t - r0) / slot;
                o.row = 2'(1 << r);
                b = NCONV - 1;
                o.counter = 8'(b ^ (b >> 1));
                o.rclk = (s == 1);
                o.wclk = (s >= 3) && (((s - 3) % 2) == 0);
            end else o.done = 1'b1;
        end
        return o;
    endfunction

    function automatic obs_t obs_of(input bit sel_b);
        obs_t o;
        if (sel_b) o = '{b_erase, b_expose, b_convert, b_counter, b_row, b_rclk, b_wclk, b_busy, b_done};
        else       o = '{a_erase, a_expose, a_convert, a_counter, a_row, a_rclk, a_wclk, a_busy, a_done};
        return o;
    endfunction

    function automatic vec_t mk(input int t, input bit er, input bit ex, input bit cv,
                                input logic [7:0] c, input logic [1:0] rs,
                                input bit rc, input bit wc, input bit bz, input bit dn);
        vec_t v;
        v.t = t;
        v.e = '{er, ex, cv, c, rs, rc, wc, bz, dn};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_start(input bit sel_b, input bit v);
        if (sel_b) start_b = v;
        else       start_a = v;
    endtask

    // One START pulse, then every cycle of the frame is compared with the model
    task automatic frame(input bit sel_b, input bit rec, input bit rnd);
        int   k, total, n_er, n_ex, n_cv, t_done, rs1, rs2, nrc, nwc, ovl, consec;
        obs_t got, prev;
        k = sel_b ? 4 : 1;
        total = E_C + X_C + NCONV + H * (3 + 2 * k);
        n_er = 0; n_ex = 0; n_cv = 0; t_done = -1;
        rs1 = 0; rs2 = 0; nrc = 0; nwc = 0; ovl = 0; consec = 0;
        prev = '0;
        @(negedge CLK); set_start(sel_b, 1'b1);
        @(negedge CLK); set_start(sel_b, 1'b0);
        for (int t = 0; t <= total + 1; t++) begin
            got = obs_of(sel_b);
            chk($sformatf("frame%0d_t%0d", k, t), 32'(got), 32'(model(t, k)));
            if (rec) trace_a[t] = got;
            n_er += int'(got.erase);
            n_ex += int'(got.expose);
            n_cv += int'(got.convert);
            if (got.done && t_done < 0) t_done = t;
            if (got.row == 2'b01) rs1++;
            if (got.row == 2'b10) rs2++;
            nrc += int'(got.rclk);
            nwc += int'(got.wclk);
            if (got.rclk && got.wclk) ovl++;
            if ((got.rclk && prev.rclk) || (got.wclk && prev.wclk)) consec++;
            prev = got;
            // START while busy must change nothing
            if (rnd && t >= 1 && t <= total - 2) set_start(sel_b, 1'($urandom_range(0, 1)));
            else if (t == 10) set_start(sel_b, 1'b1);
            else set_start(sel_b, 1'b0);
            @(negedge CLK);
        end
        set_start(sel_b, 1'b0);
        chk("erase_cycles", n_er, E_C);
        chk("expose_cycles", n_ex, X_C);
        chk("convert_cycles", n_cv, NCONV);
        chk("done_offset", t_done, total);
        chk("row0_cycles", rs1, 3 + 2 * k);
        chk("row1_cycles", rs2, 3 + 2 * k);
        chk("read_clk_pulses", nrc, H);
        chk("write_clk_pulses", nwc, H * k);
        chk("strobe_overlap", ovl, 0);
        chk("strobe_consecutive", consec, 0);
    endtask

    initial begin
        int cyc, t;
        RESET = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        // Idle after reset with START low
        for (int i = 0; i < 20; i++) begin
            chk("reset_idle_a", 32'(obs_of(1'b0)), 32'd0);
            chk("reset_idle_b", 32'(obs_of(1'b1)), 32'd0);
            @(negedge CLK);
        end

        // K=1 frame with random START noise while busy; trace kept for the table
        frame(1'b0, 1'b1, 1'b1);

        // Checkpoint table for the K=1 frame (hand-derived values)
        tbl.push_back(mk(0,   1, 0, 0, 8'h00, 2'b00, 0, 0, 1, 0));
        tbl.push_back(mk(4,   1, 0, 0, 8'h00, 2'b00, 0, 0, 1, 0));
        tbl.push_back(mk(5,   0, 1, 0, 8'h00, 2'b00, 0, 0, 1, 0));
        tbl.push_back(mk(24,  0, 1, 0, 8'h00, 2'b00, 0, 0, 1, 0));
        tbl.push_back(mk(25,  0, 0, 1, 8'h00, 2'b00, 0, 0, 1, 0));
        tbl.push_back(mk(26,  0, 0, 1, 8'h01, 2'b00, 0, 0, 1, 0));
        tbl.push_back(mk(27,  0, 0, 1, 8'h03, 2'b00, 0, 0, 1, 0));
        tbl.push_back(mk(28,  0, 0, 1, 8'h02, 2'b00, 0, 0, 1, 0));
        tbl.push_back(mk(29,  0, 0, 1, 8'h06, 2'b00, 0, 0, 1, 0));
        tbl.push_back(mk(280, 0, 0, 1, 8'h80, 2'b00, 0, 0, 1, 0));
        tbl.push_back(mk(281, 0, 0, 0, 8'h80, 2'b01, 0, 0, 1, 0));
        tbl.push_back(mk(282, 0, 0, 0, 8'h80, 2'b01, 1, 0, 1, 0));
        tbl.push_back(mk(283, 0, 0, 0, 8'h80, 2'b01, 0, 0, 1, 0));
        tbl.push_back(mk(284, 0, 0, 0, 8'h80, 2'b01, 0, 1, 1, 0));
        tbl.push_back(mk(285, 0, 0, 0, 8'h80, 2'b01, 0, 0, 1, 0));
        tbl.push_back(mk(286, 0, 0, 0, 8'h80, 2'b10, 0, 0, 1, 0));
        tbl.push_back(mk(287, 0, 0, 0, 8'h80, 2'b10, 1, 0, 1, 0));
        tbl.push_back(mk(289, 0, 0, 0, 8'h80, 2'b10, 0, 1, 1, 0));
        tbl.push_back(mk(290, 0, 0, 0, 8'h80, 2'b10, 0, 0, 1, 0));
        tbl.push_back(mk(291, 0, 0, 0, 8'h00, 2'b00, 0, 0, 1, 1));
        tbl.push_back(mk(292, 0, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0));
        foreach (tbl[i])
            chk($sformatf("table_t%0d", tbl[i].t), 32'(trace_a[tbl[i].t]), 32'(tbl[i].e));

        // K=4 readout frame
        frame(1'b1, 1'b0, 1'b1);

        // START held high: back-to-back frames with one IDLE cycle between
        @(negedge CLK); start_a = 1'b1;
        cyc = 0;
        while (!a_erase && cyc < 10) begin @(negedge CLK); cyc++; end
        chk("held_erase_rise", 32'(a_erase), 32'd1);
        t = 0;
        while (!a_done && t < 400) begin @(negedge CLK); t++; end
        chk("held_frame_len", t, 291);
        cyc = 0;
        while (!a_erase && cyc < 10) begin @(negedge CLK); cyc++; end
        chk("held_gap", cyc, 2);
        start_a = 1'b0;
        cyc = 0;
        while (a_busy && cyc < 400) begin @(negedge CLK); cyc++; end
        chk("held_drain_idle", 32'(a_busy), 32'd0);

        // Reset mid-CONVERT at code 8'h2A
        @(negedge CLK); start_a = 1'b1;
        @(negedge CLK); start_a = 1'b0;
        cyc = 0;
        while (!(a_convert && a_counter == 8'h2A) && cyc < 400) begin @(negedge CLK); cyc++; end
        chk("reach_2a", 32'(a_counter), 32'h2A);
        #2 RESET = 1'b1;
        #1 chk("async_reset_clear", 32'(obs_of(1'b0)), 32'd0);
        @(negedge CLK); RESET = 1'b0;
        repeat (2) @(negedge CLK);
        chk("after_reset_idle", 32'(obs_of(1'b0)), 32'd0);
        frame(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
